// File: rtl/quad_spi_pkg.sv
// Shared definitions for the quad-SPI blocks: the master frame FSM state
// encoding and the lane count (one nibble per sclk cycle).
// Ports: none (package).
package quad_spi_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    HOLD  = 3'd4,
    GAP   = 3'd5
  } qspi_state_t;

endpackage

// File: rtl/quad_spi_master_if.sv
// System-side byte interface of the quad-SPI master.
// Ports: tx_data/tx_valid (request), tx_ready/busy (status), rx_data/rx_valid (response).
// master = system requester, slave = the quad_spi_master block.
interface quad_spi_master_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid, busy
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid, busy
  );
endinterface

// File: rtl/quad_spi_master.sv
// Quad-SPI master: one DATA_W frame per chip select, a nibble per sclk, MS nibble first, full duplex.
// Latency: rx_valid (2N+1)*CLK_DIV clocks after acceptance; ready again after (2N+2)*CLK_DIV.
// Backpressure: tx_ready low for the whole frame; requests while busy are ignored.
// Ports: clk, reset_n (async active-low), sys (byte interface, slave modport),
//        sclk/cs_n/mosi[3:0] to the slave pins, miso[3:0] from the slave.
module quad_spi_master
  import quad_spi_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int DATA_W  = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  quad_spi_master_if.slave    sys,
  output logic                sclk,
  output logic                cs_n,
  output logic [NIBBLE_W-1:0] mosi,
  input  logic [NIBBLE_W-1:0] miso
);

  localparam int N  = DATA_W / NIBBLE_W;
  localparam int CW = $clog2(CLK_DIV);
  localparam int NW = (N > 1) ? $clog2(N) : 1;

  localparam logic [CW-1:0] CNT_LOAD = CW'(CLK_DIV - 1);
  localparam logic [NW-1:0] NIB_LAST = NW'(N - 1);

  qspi_state_t         state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NW-1:0]       nib_q, nib_d;
  logic [DATA_W-1:0]   tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                sclk_q, sclk_d;
  logic                cs_n_q, cs_n_d;
  logic [NIBBLE_W-1:0] mosi_q, mosi_d;
  logic                tx_ready_q, tx_ready_d;
  logic                busy_q, busy_d;

  logic              expire;
  logic              last_nib;
  logic              accept;
  logic [DATA_W-1:0] tx_next;

  assign expire   = (cnt_q == '0);
  assign last_nib = (nib_q == NIB_LAST);
  assign tx_next  = tx_sh_q << NIBBLE_W;

  // A request waiting at GAP expiry starts the next frame on that same edge,
  // so back-to-back frames keep cs_n high for exactly CLK_DIV clocks.
  assign accept = sys.tx_valid && ((state_q == IDLE) || ((state_q == GAP) && expire));

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      nib_q      <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      mosi_q     <= '0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      nib_q      <= nib_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   if (expire) state_d = HIGH;
      HIGH:    if (expire) state_d = last_nib ? HOLD : LOW;
      LOW:     if (expire) state_d = HIGH;
      HOLD:    if (expire) state_d = GAP;
      GAP:     if (expire) state_d = accept ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    // The divider reloads on every state expiry and sits preloaded in IDLE.
    cnt_d      = (expire || (state_q == IDLE)) ? CNT_LOAD : cnt_q - 1'b1;
    nib_d      = nib_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    mosi_d     = mosi_q;
    tx_ready_d = tx_ready_q;
    busy_d     = busy_q;

    if (accept) begin
      tx_sh_d    = sys.tx_data;
      mosi_d     = sys.tx_data[DATA_W-1 -: NIBBLE_W];
      rx_sh_d    = '0;
      nib_d      = '0;
      cs_n_d     = 1'b0;
      tx_ready_d = 1'b0;
      busy_d     = 1'b1;
    end else begin
      unique case (state_q)
        SETUP, LOW: begin
          if (expire) sclk_d = 1'b1;
        end
        HIGH: begin
          if (expire) begin
            sclk_d  = 1'b0;
            // miso has been stable for the whole high phase; sample it here.
            rx_sh_d = (rx_sh_q << NIBBLE_W) | DATA_W'(miso);
            if (!last_nib) begin
              tx_sh_d = tx_next;
              mosi_d  = tx_next[DATA_W-1 -: NIBBLE_W];
              nib_d   = nib_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (expire) begin
            cs_n_d     = 1'b1;
            mosi_d     = '0;
            rx_data_d  = rx_sh_q;
            rx_valid_d = 1'b1;
          end
        end
        GAP: begin
          if (expire) begin
            tx_ready_d = 1'b1;
            busy_d     = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign sys.tx_ready = tx_ready_q;
  assign sys.busy     = busy_q;
  assign sys.rx_data  = rx_data_q;
  assign sys.rx_valid = rx_valid_q;
  assign sclk         = sclk_q;
  assign cs_n         = cs_n_q;
  assign mosi         = mosi_q;

endmodule

// File: tb/tb_quad_spi_master.sv
// Bench for quad_spi_master: three instances (D=2/8b, D=3/8b, D=2/16b), each
// against a behavioural Quad-SPI slave, with a per-instance scoreboard queue.
module tb_quad_spi_master;

  logic clk = 1'b0;
  logic rst0_n, rst_n;
  always #5 clk = ~clk;

  quad_spi_master_if #(.DATA_W(8))  if0 ();
  quad_spi_master_if #(.DATA_W(8))  if1 ();
  quad_spi_master_if #(.DATA_W(16)) if2 ();

  logic       sclk0, cs_n0, sclk1, cs_n1, sclk2, cs_n2;
  logic [3:0] mosi0, miso0, mosi1, miso1, mosi2, miso2;

  quad_spi_master #(.CLK_DIV(2), .DATA_W(8)) u0 (
    .clk(clk), .reset_n(rst0_n), .sys(if0.slave),
    .sclk(sclk0), .cs_n(cs_n0), .mosi(mosi0), .miso(miso0));
  quad_spi_master #(.CLK_DIV(3), .DATA_W(8)) u1 (
    .clk(clk), .reset_n(rst_n), .sys(if1.slave),
    .sclk(sclk1), .cs_n(cs_n1), .mosi(mosi1), .miso(miso1));
  quad_spi_master #(.CLK_DIV(2), .DATA_W(16)) u2 (
    .clk(clk), .reset_n(rst_n), .sys(if2.slave),
    .sclk(sclk2), .cs_n(cs_n2), .mosi(mosi2), .miso(miso2));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural slaves: present nibble k while sclk is high, advance on the
  // falling edge; capture mosi while sclk is high.
  logic [7:0]  s0_dat = '0, s0_tx = '0, s0_rx = '0;
  logic [7:0]  s1_dat = '0, s1_tx = '0, s1_rx = '0;
  logic [15:0] s2_dat = '0, s2_tx = '0, s2_rx = '0;
  int s0_k = 0, s1_k = 0, s2_k = 0;
  int fr0 = 0, rxc0 = 0, rxc1 = 0, rxc2 = 0;
  logic [31:0] q0[$], q1[$], q2[$];

  always @(negedge cs_n0) begin
    s0_tx = s0_dat; s0_rx = '0; s0_k = 0; fr0++;
    q0.push_back({16'(s0_dat), 16'(if0.tx_data)});
  end
  always @(negedge cs_n1) begin
    s1_tx = s1_dat; s1_rx = '0; s1_k = 0;
    q1.push_back({16'(s1_dat), 16'(if1.tx_data)});
  end
  always @(negedge cs_n2) begin
    s2_tx = s2_dat; s2_rx = '0; s2_k = 0;
    q2.push_back({s2_dat, if2.tx_data});
  end

  always @(posedge sclk0) s0_rx = {s0_rx[3:0], mosi0};
  always @(posedge sclk1) s1_rx = {s1_rx[3:0], mosi1};
  always @(posedge sclk2) s2_rx = {s2_rx[11:0], mosi2};
  always @(negedge sclk0) s0_k++;
  always @(negedge sclk1) s1_k++;
  always @(negedge sclk2) s2_k++;

  assign miso0 = (cs_n0 !== 1'b0) ? 4'bxxxx : ((s0_k < 2) ? s0_tx[7-4*s0_k -: 4] : 4'h0);
  assign miso1 = (cs_n1 !== 1'b0) ? 4'bxxxx : ((s1_k < 2) ? s1_tx[7-4*s1_k -: 4] : 4'h0);
  assign miso2 = (cs_n2 !== 1'b0) ? 4'bxxxx : ((s2_k < 4) ? s2_tx[15-4*s2_k -: 4] : 4'h0);

  // Scoreboard: each completed frame pops the expectation pushed at cs_n fall.
  always @(negedge clk) begin
    logic [31:0] e;
    if (if0.rx_valid === 1'b1) begin
      chk("u0_rxv_expected", 32'(q0.size() != 0), 1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        chk("u0_rx_data", 32'(if0.rx_data), 32'(e[23:16]));
        chk("u0_slave_rx", 32'(s0_rx), 32'(e[7:0]));
        rxc0++;
      end
    end
    if (if1.rx_valid === 1'b1) begin
      chk("u1_rxv_expected", 32'(q1.size() != 0), 1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        chk("u1_rx_data", 32'(if1.rx_data), 32'(e[23:16]));
        chk("u1_slave_rx", 32'(s1_rx), 32'(e[7:0]));
        rxc1++;
      end
    end
    if (if2.rx_valid === 1'b1) begin
      chk("u2_rxv_expected", 32'(q2.size() != 0), 1);
      if (q2.size() != 0) begin
        e = q2.pop_front();
        chk("u2_rx_data", 32'(if2.rx_data), 32'(e[31:16]));
        chk("u2_slave_rx", 32'(s2_rx), 32'(e[15:0]));
        rxc2++;
      end
    end
  end

  initial begin
    int rxv_at, rdy_at, gap, base, pulses, cslow, hi;
    logic prev;
    int hq[$];
    logic [3:0] mq[$];

    rst0_n = 1'b0; rst_n = 1'b0;
    if0.tx_valid = 1'b0; if0.tx_data = '0;
    if1.tx_valid = 1'b0; if1.tx_data = '0;
    if2.tx_valid = 1'b0; if2.tx_data = '0;
    repeat (3) @(negedge clk);

    // Reset state: {cs_n, sclk, mosi, tx_ready, busy, rx_valid}
    chk("u0_reset_pins", {cs_n0, sclk0, mosi0, if0.tx_ready, if0.busy, if0.rx_valid}, 9'b1_0_0000_1_0_0);
    chk("u1_reset_pins", {cs_n1, sclk1, mosi1, if1.tx_ready, if1.busy, if1.rx_valid}, 9'b1_0_0000_1_0_0);
    chk("u2_reset_pins", {cs_n2, sclk2, mosi2, if2.tx_ready, if2.busy, if2.rx_valid}, 9'b1_0_0000_1_0_0);
    chk("u0_reset_rx", 32'(if0.rx_data), 0);
    chk("u2_reset_rx", 32'(if2.rx_data), 0);
    rst0_n = 1'b1; rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Loopback D=2: A5 out, 3C back; rx_valid after E10, tx_ready after E12
    if0.tx_data = 8'hA5; s0_dat = 8'h3C; if0.tx_valid = 1'b1;
    @(negedge clk);
    if0.tx_valid = 1'b0;
    chk("t1_cs_low", 32'(cs_n0), 0);
    chk("t1_busy", 32'(if0.busy), 1);
    rxv_at = -1; rdy_at = -1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (if0.rx_valid && rxv_at < 0) rxv_at = c;
      if (if0.tx_ready && rdy_at < 0) rdy_at = c;
    end
    chk("t1_rxv_cycle", 32'(rxv_at), 10);
    chk("t1_rdy_cycle", 32'(rdy_at), 12);
    chk("t1_busy_end", 32'(if0.busy), 0);

    // Pin timing D=3: F0
    if1.tx_data = 8'hF0; s1_dat = 8'h69; if1.tx_valid = 1'b1;
    pulses = 0; cslow = 0; hi = 0; prev = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if1.tx_valid = 1'b0;
      if (!cs_n1) cslow++;
      if (sclk1) begin
        if (!prev) begin mq.push_back(mosi1); pulses++; end
        hi++;
      end else if (prev) begin
        hq.push_back(hi); hi = 0;
      end
      prev = sclk1;
    end
    chk("t2_pulses", 32'(pulses), 2);
    chk("t2_hi0_len", 32'(hq[0]), 3);
    chk("t2_hi1_len", 32'(hq[1]), 3);
    chk("t2_mosi0", 32'(mq[0]), 32'hF);
    chk("t2_mosi1", 32'(mq[1]), 32'h0);
    chk("t2_cs_low_len", 32'(cslow), 15);

    // Back-to-back D=2: 12 then 34 with tx_valid held
    base = rxc0;
    if0.tx_data = 8'h12; s0_dat = 8'h8B; if0.tx_valid = 1'b1;
    for (int i = 0; i < 10 && cs_n0; i++) @(negedge clk);
    chk("t3_start", 32'(cs_n0), 0);
    if0.tx_data = 8'h34; s0_dat = 8'hAD;
    for (int i = 0; i < 30 && !if0.rx_valid; i++) @(negedge clk);
    chk("t3_first_rxv", 32'(if0.rx_valid), 1);
    gap = 0;
    for (int i = 0; i < 10 && cs_n0; i++) begin gap++; @(negedge clk); end
    if0.tx_valid = 1'b0;
    chk("t3_gap_len", 32'(gap), 2);
    repeat (20) @(negedge clk);
    chk("t3_rx_count", 32'(rxc0 - base), 2);

    // Busy ignore: EE pulsed mid-frame
    base = fr0;
    if0.tx_data = 8'hC3; s0_dat = 8'h5E; if0.tx_valid = 1'b1;
    @(negedge clk);
    if0.tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    if0.tx_data = 8'hEE; if0.tx_valid = 1'b1;
    @(negedge clk);
    if0.tx_valid = 1'b0;
    chk("t4_busy", 32'(if0.busy), 1);
    chk("t4_mosi", 32'(mosi0), 32'h3);
    repeat (20) @(negedge clk);
    chk("t4_frames", 32'(fr0 - base), 1);

    // Reset mid-frame, then 5A completes normally
    base = rxc0;
    if0.tx_data = 8'h77; s0_dat = 8'h11; if0.tx_valid = 1'b1;
    @(negedge clk);
    if0.tx_valid = 1'b0;
    for (int i = 0; i < 20 && !sclk0; i++) @(negedge clk);
    chk("t5_sclk_rose", 32'(sclk0), 1);
    #2 rst0_n = 1'b0;
    q0.delete();
    #1;
    chk("t5_async_pins", {cs_n0, sclk0, mosi0}, 6'b1_0_0000);
    chk("t5_rx_cleared", 32'(if0.rx_data), 0);
    @(negedge clk);
    rst0_n = 1'b1;
    repeat (16) @(negedge clk);
    chk("t5_no_rxv", 32'(rxc0 - base), 0);
    if0.tx_data = 8'h5A; s0_dat = 8'hC3; if0.tx_valid = 1'b1;
    @(negedge clk);
    if0.tx_valid = 1'b0;
    repeat (16) @(negedge clk);
    chk("t5_after_reset", 32'(rxc0 - base), 1);

    // DATA_W=16, D=2: BEEF, rx_valid after E18, 4 sclk pulses
    if2.tx_data = 16'hBEEF; s2_dat = 16'hC0DE; if2.tx_valid = 1'b1;
    @(negedge clk);
    if2.tx_valid = 1'b0;
    rxv_at = -1; pulses = 0; prev = sclk2;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (if2.rx_valid && rxv_at < 0) rxv_at = c;
      if (sclk2 && !prev) pulses++;
      prev = sclk2;
    end
    chk("t6_rxv_cycle", 32'(rxv_at), 18);
    chk("t6_pulses", 32'(pulses), 4);

    chk("q0_drained", 32'(q0.size()), 0);
    chk("q1_drained", 32'(q1.size()), 0);
    chk("q2_drained", 32'(q2.size()), 0);
    chk("u1_rx_count", 32'(rxc1), 1);
    chk("u2_rx_count", 32'(rxc2), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
